// File: rtl/ro_puf_engine.sv
// Ring-oscillator PUF engine: counts rising edges of two challenge-selected
// oscillators per response bit over a programmable window and compares them.
`timescale 1ns/1ps
module ro_puf_engine #(
    parameter  int NUM_RO    = 16,
    parameter  int CNT_W     = 16,
    parameter  int WIN_W     = 16,
    parameter  int RESP_BITS = 8,
    localparam int SEL_W     = $clog2(NUM_RO)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RO-1:0]    ro_in,
    output logic                 ro_en,
    input  logic                 start,
    input  logic [SEL_W-1:0]     challenge,
    input  logic [WIN_W-1:0]     win_len,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response,
    output logic [RESP_BITS-1:0] tie_mask,
    output logic                 response_valid
);
    localparam int               IDX_W    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [SEL_W-1:0]  chal_q;
    logic [WIN_W-1:0]  win_q;
    logic [WIN_W-1:0]  win_cnt;
    logic              arm_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;

    logic [NUM_RO-1:0] sync1;
    logic [NUM_RO-1:0] sync2;
    logic [NUM_RO-1:0] hist;
    logic [NUM_RO-1:0] ro_rise;

    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic              meas_last;
    logic              cmp_last;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, like real hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= ro_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign ro_rise = sync2 & ~hist;

    // Truncation to SEL_W bits is the modulo-NUM_RO wrap (NUM_RO is a power of two).
    assign sel_a     = SEL_W'(int'(chal_q) + 2 * int'(bit_idx));
    assign sel_b     = SEL_W'(int'(chal_q) + 2 * int'(bit_idx) + 1);
    assign meas_last = (win_cnt == win_q - WIN_W'(1));
    assign cmp_last  = (bit_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        ro_en     = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_ARM;
            end
            S_ARM: begin
                ro_en = 1'b1;
                if (arm_cnt) state_nxt = S_MEASURE;
            end
            S_MEASURE: begin
                ro_en = 1'b1;
                if (meas_last) state_nxt = S_COMPARE;
            end
            S_COMPARE: begin
                state_nxt = cmp_last ? S_DONE : S_ARM;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chal_q         <= '0;
            win_q          <= '0;
            win_cnt        <= '0;
            arm_cnt        <= 1'b0;
            bit_idx        <= '0;
            cnt_a          <= '0;
            cnt_b          <= '0;
            response       <= '0;
            tie_mask       <= '0;
            response_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        chal_q         <= challenge;
                        win_q          <= (win_len == '0) ? WIN_W'(1) : win_len;
                        bit_idx        <= '0;
                        response       <= '0;
                        tie_mask       <= '0;
                        response_valid <= 1'b0;
                    end
                end
                S_ARM: begin
                    arm_cnt <= ~arm_cnt;
                    win_cnt <= '0;
                    cnt_a   <= '0;
                    cnt_b   <= '0;
                end
                S_MEASURE: begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    if (ro_rise[sel_a] && (cnt_a != '1)) cnt_a <= cnt_a + CNT_W'(1);
                    if (ro_rise[sel_b] && (cnt_b != '1)) cnt_b <= cnt_b + CNT_W'(1);
                end
                S_COMPARE: begin
                    response[bit_idx] <= (cnt_a > cnt_b);
                    tie_mask[bit_idx] <= (cnt_a == cnt_b);
                    // Raised together with the last bit so it is already high while done pulses.
                    if (cmp_last) response_valid <= 1'b1;
                    else          bit_idx        <= bit_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
